// File: rtl/tm_lif_scheduler.sv
// Round-robin sequencer for a time-multiplexed leaky-integrate-and-fire array.
// One shared update datapath walks all slots per step and publishes the spike vector.
module tm_lif_scheduler #(
    parameter int N_NEURONS  = 8,
    parameter int W          = 8,
    parameter int TH_RESET   = 127,
    parameter int LEAK_SHIFT = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          step_start,
    output logic                          busy,
    input  logic                          cfg_we,
    input  logic [$clog2(N_NEURONS)-1:0]  cfg_addr,
    input  logic [W-1:0]                  cfg_data,
    output logic                          cfg_ready,
    output logic                          cur_req,
    output logic [$clog2(N_NEURONS)-1:0]  cur_idx,
    input  logic                          cur_valid,
    input  logic [W-1:0]                  cur_data,
    output logic [N_NEURONS-1:0]          spikes,
    output logic                          spike_valid,
    input  logic [$clog2(N_NEURONS)-1:0]  dbg_addr,
    output logic [W-1:0]                  dbg_state
);
    localparam int AW = $clog2(N_NEURONS);
    localparam logic [AW:0]   NSLOTS = (AW+1)'(N_NEURONS);
    localparam logic [AW-1:0] LAST   = AW'(N_NEURONS - 1);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_UPDATE, S_DONE} fsm_t;

    fsm_t                 r_fsm;
    logic [W-1:0]         r_mem [N_NEURONS];
    logic [W-1:0]         r_th  [N_NEURONS];
    logic [AW-1:0]        r_idx;
    logic [W-1:0]         r_cur;
    logic [N_NEURONS-1:0] r_acc;
    logic [N_NEURONS-1:0] r_spikes;
    logic                 r_spike_valid;
    logic                 r_busy;
    logic                 r_cur_req;

    logic [W-1:0]         w_leak;
    logic [W:0]           w_sum;
    logic [W-1:0]         w_sat;
    logic                 w_spk;
    logic [N_NEURONS-1:0] w_acc_next;
    logic                 w_cfg_hit;

    // Sum is one bit wider than the state so overflow can be clamped to all-ones.
    always_comb begin
        w_leak     = r_mem[r_idx] >> LEAK_SHIFT;
        w_sum      = {1'b0, r_cur} + {1'b0, w_leak};
        w_sat      = w_sum[W] ? '1 : w_sum[W-1:0];
        w_spk      = (w_sat >= r_th[r_idx]);
        w_acc_next = r_acc;
        w_acc_next[r_idx] = w_spk;
        w_cfg_hit  = cfg_we && ({1'b0, cfg_addr} < NSLOTS);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm         <= S_IDLE;
            r_idx         <= '0;
            r_cur         <= '0;
            r_acc         <= '0;
            r_spikes      <= '0;
            r_spike_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_cur_req     <= 1'b0;
            for (int unsigned i = 0; i < N_NEURONS; i++) begin
                r_mem[i] <= '0;
                r_th[i]  <= W'(TH_RESET);
            end
        end else begin
            r_spike_valid <= 1'b0;
            case (r_fsm)
                S_IDLE: begin
                    if (w_cfg_hit)
                        r_th[cfg_addr] <= cfg_data;
                    if (step_start) begin
                        r_idx     <= '0;
                        r_busy    <= 1'b1;
                        r_cur_req <= 1'b1;
                        r_fsm     <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (cur_valid) begin
                        r_cur     <= cur_data;
                        r_cur_req <= 1'b0;
                        r_fsm     <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    r_mem[r_idx] <= w_spk ? '0 : w_sat;
                    r_acc        <= w_acc_next;
                    if (r_idx == LAST) begin
                        r_spikes      <= w_acc_next;
                        r_spike_valid <= 1'b1;
                        r_fsm         <= S_DONE;
                    end else begin
                        r_idx     <= r_idx + 1'b1;
                        r_cur_req <= 1'b1;
                        r_fsm     <= S_FETCH;
                    end
                end
                S_DONE: begin
                    r_busy <= 1'b0;
                    r_fsm  <= S_IDLE;
                end
                default: r_fsm <= S_IDLE;
            endcase
        end
    end

    assign busy        = r_busy;
    assign cfg_ready   = ~r_busy;
    assign cur_req     = r_cur_req;
    assign cur_idx     = r_idx;
    assign spikes      = r_spikes;
    assign spike_valid = r_spike_valid;
    assign dbg_state   = r_mem[dbg_addr];

endmodule

// File: tb/tb_tm_lif_scheduler.sv
// Directed self-checking bench for tm_lif_scheduler (N=8, W=8, threshold 127, leak >>1).
module tb_tm_lif_scheduler;
    logic       clk = 1'b0;
    logic       rst;
    logic       step_start;
    logic       busy;
    logic       cfg_we;
    logic [2:0] cfg_addr;
    logic [7:0] cfg_data;
    logic       cfg_ready;
    logic       cur_req;
    logic [2:0] cur_idx;
    logic       cur_valid;
    logic [7:0] cur_data;
    logic [7:0] spikes;
    logic       spike_valid;
    logic [2:0] dbg_addr;
    logic [7:0] dbg_state;

    int tests  = 0;
    int failed = 0;

    tm_lif_scheduler #(
        .N_NEURONS (8),
        .W         (8),
        .TH_RESET  (127),
        .LEAK_SHIFT(1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .step_start (step_start),
        .busy       (busy),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .cfg_ready  (cfg_ready),
        .cur_req    (cur_req),
        .cur_idx    (cur_idx),
        .cur_valid  (cur_valid),
        .cur_data   (cur_data),
        .spikes     (spikes),
        .spike_valid(spike_valid),
        .dbg_addr   (dbg_addr),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic write_th(input int slot, input logic [7:0] val);
        cfg_we   = 1'b1;
        cfg_addr = 3'(slot);
        cfg_data = val;
        tick();
        cfg_we   = 1'b0;
    endtask

    // Returns edges from the step_start edge (counted as 1) up to the spike_valid cycle.
    // While the slot stall_slot is requested, cur_valid is held low for stall_len cycles;
    // with poke set, a threshold write to slot 0 and a step_start are driven mid-stall.
    task automatic run_step(input int stall_slot, input int stall_len, input bit poke,
                            output int n);
        int stalled;
        stalled    = 0;
        step_start = 1'b1;
        cur_valid  = 1'b1;
        tick();
        step_start = 1'b0;
        cfg_we     = 1'b0;
        n = 1;
        while (!spike_valid && n < 200) begin
            if (cur_req && cur_idx == 3'(stall_slot) && stalled < stall_len) begin
                cur_valid = 1'b0;
                stalled++;
                if (poke && stalled == 2) begin
                    cfg_we     = 1'b1;
                    cfg_addr   = 3'd0;
                    cfg_data   = 8'd5;
                    step_start = 1'b1;
                end
            end else begin
                cur_valid = 1'b1;
            end
            tick();
            n++;
            cfg_we     = 1'b0;
            step_start = 1'b0;
        end
        cur_valid = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (spikes !== 8'h00) begin failed++; $display("FAIL reset_spikes: got %0h expected 00", spikes); end
        tests++; if (spike_valid !== 1'b0) begin failed++; $display("FAIL reset_spike_valid: got %0b expected 0", spike_valid); end
        tests++; if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        tests++; if (cfg_ready !== 1'b1) begin failed++; $display("FAIL reset_cfg_ready: got %0b expected 1", cfg_ready); end
        tests++; if (cur_req !== 1'b0) begin failed++; $display("FAIL reset_cur_req: got %0b expected 0", cur_req); end
        tests++; if (cur_idx !== 3'd0) begin failed++; $display("FAIL reset_cur_idx: got %0d expected 0", cur_idx); end
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            tests++; if (dbg_state !== 8'd0) begin failed++; $display("FAIL reset_state slot %0d: got %0d expected 0", i, dbg_state); end
        end
    endtask

    task automatic test_two_steps();
        int n;
        do_reset();
        cur_data = 8'd100;
        run_step(-1, 0, 1'b0, n);
        tests++; if (n !== 17) begin failed++; $display("FAIL step1_latency: got %0d expected 17", n); end
        tests++; if (spikes !== 8'h00) begin failed++; $display("FAIL step1_spikes: got %0h expected 00", spikes); end
        tests++; if (busy !== 1'b1) begin failed++; $display("FAIL done_busy: got %0b expected 1", busy); end
        tick();
        tests++; if (busy !== 1'b0) begin failed++; $display("FAIL idle_busy: got %0b expected 0", busy); end
        tests++; if (spike_valid !== 1'b0) begin failed++; $display("FAIL spike_valid_pulse: got %0b expected 0", spike_valid); end
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i); #1;
            tests++; if (dbg_state !== 8'd100) begin failed++; $display("FAIL step1_state slot %0d: got %0d expected 100", i, dbg_state); end
        end
        run_step(-1, 0, 1'b0, n);
        tests++; if (n !== 17) begin failed++; $display("FAIL step2_latency: got %0d expected 17", n); end
        tests++; if (spikes !== 8'hFF) begin failed++; $display("FAIL step2_spikes: got %0h expected ff", spikes); end
        tick();
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i); #1;
            tests++; if (dbg_state !== 8'd0) begin failed++; $display("FAIL step2_state slot %0d: got %0d expected 0", i, dbg_state); end
        end
    endtask

    task automatic test_saturation();
        int n;
        logic [7:0] exp_spk [3];
        logic [7:0] exp_st  [3];
        exp_spk[0] = 8'h00; exp_st[0] = 8'd200;
        exp_spk[1] = 8'hFF; exp_st[1] = 8'd0;
        exp_spk[2] = 8'h00; exp_st[2] = 8'd200;
        do_reset();
        for (int i = 0; i < 8; i++) write_th(i, 8'd255);
        cur_data = 8'd200;
        for (int s = 0; s < 3; s++) begin
            run_step(-1, 0, 1'b0, n);
            tests++; if (spikes !== exp_spk[s]) begin failed++; $display("FAIL sat_spikes step %0d: got %0h expected %0h", s + 1, spikes, exp_spk[s]); end
            tick();
            dbg_addr = 3'd5; #1;
            tests++; if (dbg_state !== exp_st[s]) begin failed++; $display("FAIL sat_state step %0d: got %0d expected %0d", s + 1, dbg_state, exp_st[s]); end
        end
    endtask

    task automatic test_per_slot_cfg();
        int n;
        do_reset();
        for (int i = 0; i < 8; i++) if (i != 3) write_th(i, 8'd255);
        // slot 3 written on the same edge as step_start
        cfg_we   = 1'b1;
        cfg_addr = 3'd3;
        cfg_data = 8'd0;
        cur_data = 8'd10;
        run_step(-1, 0, 1'b0, n);
        tests++; if (spikes !== 8'h08) begin failed++; $display("FAIL cfg_spikes: got %0h expected 08", spikes); end
        tick();
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i); #1;
            tests++;
            if (dbg_state !== ((i == 3) ? 8'd0 : 8'd10)) begin
                failed++; $display("FAIL cfg_state slot %0d: got %0d expected %0d", i, dbg_state, (i == 3) ? 0 : 10);
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        bit saw_req;
        do_reset();
        cur_data = 8'd100;
        // Observe the stall directly: hold cur_valid low while slot 2 is requested.
        step_start = 1'b1; cur_valid = 1'b1;
        tick();
        step_start = 1'b0;
        saw_req = 1'b0;
        for (int k = 0; k < 40 && !saw_req; k++) begin
            if (cur_req && cur_idx == 3'd2) saw_req = 1'b1;
            else tick();
        end
        tests++; if (saw_req !== 1'b1) begin failed++; $display("FAIL bp_reach_slot2: got %0b expected 1", saw_req); end
        cur_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            tests++;
            if (cur_req !== 1'b1 || cur_idx !== 3'd2) begin
                failed++; $display("FAIL bp_hold cycle %0d: got req=%0b idx=%0d expected req=1 idx=2", k, cur_req, cur_idx);
            end
        end
        cur_valid = 1'b1;
        do_reset();
        cur_data = 8'd100;
        run_step(2, 5, 1'b1, n);
        tests++; if (n !== 22) begin failed++; $display("FAIL bp_latency: got %0d expected 22", n); end
        tests++; if (spikes !== 8'h00) begin failed++; $display("FAIL bp_spikes: got %0h expected 00", spikes); end
        tick(); tick(); tick();
        tests++; if (busy !== 1'b0) begin failed++; $display("FAIL bp_no_second_step: got busy=%0b expected 0", busy); end
        // states are 100; with zero current 50 < 127, so slot 0 spikes only if the stalled write landed
        cur_data = 8'd0;
        run_step(-1, 0, 1'b0, n);
        tests++; if (spikes !== 8'h00) begin failed++; $display("FAIL bp_cfg_dropped: got %0h expected 00", spikes); end
        tick();
    endtask

    task automatic test_reset_mid_step();
        int n;
        bit seen_sv;
        do_reset();
        cur_data = 8'd100;
        step_start = 1'b1; cur_valid = 1'b1;
        tick();
        step_start = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (cur_req && cur_idx == 3'd4) break;
            tick();
        end
        tests++; if (cur_idx !== 3'd4) begin failed++; $display("FAIL mid_reach_slot4: got %0d expected 4", cur_idx); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++; if (busy !== 1'b0) begin failed++; $display("FAIL mid_busy: got %0b expected 0", busy); end
        tests++; if (cur_req !== 1'b0) begin failed++; $display("FAIL mid_cur_req: got %0b expected 0", cur_req); end
        seen_sv = 1'b0;
        for (int k = 0; k < 25; k++) begin
            if (spike_valid) seen_sv = 1'b1;
            tick();
        end
        tests++; if (seen_sv !== 1'b0) begin failed++; $display("FAIL mid_no_spike_valid: got %0b expected 0", seen_sv); end
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i); #1;
            tests++; if (dbg_state !== 8'd0) begin failed++; $display("FAIL mid_state slot %0d: got %0d expected 0", i, dbg_state); end
        end
        run_step(-1, 0, 1'b0, n);
        tests++; if (n !== 17) begin failed++; $display("FAIL mid_restart_latency: got %0d expected 17", n); end
        tests++; if (spikes !== 8'h00) begin failed++; $display("FAIL mid_restart_spikes: got %0h expected 00", spikes); end
        tick();
        dbg_addr = 3'd4; #1;
        tests++; if (dbg_state !== 8'd100) begin failed++; $display("FAIL mid_restart_state: got %0d expected 100", dbg_state); end
    endtask

    initial begin
        rst        = 1'b1;
        step_start = 1'b0;
        cfg_we     = 1'b0;
        cfg_addr   = '0;
        cfg_data   = '0;
        cur_valid  = 1'b1;
        cur_data   = '0;
        dbg_addr   = '0;
        test_reset();
        test_two_steps();
        test_saturation();
        test_per_slot_cfg();
        test_backpressure();
        test_reset_mid_step();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/tm_lif_scheduler.md
Name: tm_lif_scheduler

Overview:
Sequencer for a time-multiplexed leaky-integrate-and-fire neuron array. One shared update datapath (next = current + (state >> LEAK_SHIFT)) serves N neuron slots in round-robin order. The block owns per-slot membrane state and thresholds, fetches each slot's input current from upstream over a req/valid handshake, and publishes the full spike vector once per step. It sits between the stimulus source and the spike consumer in the neuron core.

Parameters:
N_NEURONS, 8, number of time-multiplexed neuron slots (2..16)
W, 8, membrane state / current / threshold width (bits)
TH_RESET, 127, threshold value loaded into every slot at reset
LEAK_SHIFT, 1, right-shift applied to stored state each update (leak)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
step_start  in  1  pulse: begin one update step over all slots; honoured only when busy=0
busy  out  1  high while a step is in progress (FSM not IDLE)
cfg_we  in  1  threshold write strobe
cfg_addr  in  clog2(N_NEURONS)  slot index for threshold write
cfg_data  in  W  threshold value
cfg_ready  out  1  high when a threshold write is accepted (FSM in IDLE)
cur_req  out  1  current requested for slot cur_idx
cur_idx  out  clog2(N_NEURONS)  slot whose current is requested
cur_valid  in  1  upstream current valid; accepted when cur_req=1
cur_data  in  W  input current for slot cur_idx
spikes  out  N_NEURONS  spike vector from the last completed step, bit i = slot i
spike_valid  out  1  one-cycle pulse when spikes updates
dbg_addr  in  clog2(N_NEURONS)  state readback index
dbg_state  out  W  combinational readback of membrane state[dbg_addr]

Behaviour:
- Reset (sync, rst=1 at clk edge): all states 0, all thresholds TH_RESET, spikes 0, spike_valid 0, cur_req 0, cur_idx 0, busy 0, FSM IDLE. Asserted mid-step: step aborts, no spike_valid, partial state updates discarded (states cleared).
- FSM states: IDLE, FETCH, UPDATE, DONE.
- IDLE: busy=0, cfg_ready=1. step_start=1 -> slot index i=0, go FETCH.
- FETCH: cur_req=1, cur_idx=i. On edge with cur_valid=1: latch cur_data, go UPDATE. cur_valid=0 -> stay (unbounded stall allowed). cur_valid outside FETCH ignored.
- UPDATE (exactly 1 cycle, cur_req=0): sum = latched current + (state[i] >> LEAK_SHIFT), computed W+1 bits wide, saturated to 2^W-1. spk = (sat_sum >= threshold[i]), unsigned compare. state[i] <= spk ? 0 : sat_sum. Spike accumulator bit i <= spk. If i == N_NEURONS-1: spikes <= accumulator including bit i on this edge, go DONE. Else i <= i+1, go FETCH.
- DONE (1 cycle): spike_valid=1, busy=1, then IDLE. spikes holds until next step's final UPDATE edge.
- Latency with cur_valid tied high: step_start sampled at edge 0 -> FETCH in cycle 1; 2 cycles per slot; spike_valid high in cycle 2*N_NEURONS+1 (cycle 17 for N=8); busy low again from cycle 18; next step_start accepted in cycle 18.
- step_start while busy=1: ignored, not queued.
- Config: write occurs on edge where cfg_we=1 and FSM=IDLE; cfg_we while busy dropped silently. cfg_addr >= N_NEURONS ignored. cfg_we and step_start on the same IDLE edge: both take effect; the step uses the new threshold.
- Threshold 0: slot spikes on every update (state returns to 0 each time). Threshold 2^W-1: spikes only at saturation.
- dbg_state reflects register contents (post-edge value); no side effects.

Test Plan:
- Reset: hold rst 2 cycles -> spikes=0x00, spike_valid=0, busy=0, cfg_ready=1, dbg_state=0 and cur_req=0 for all slots.
- Two steps, cur_valid=1, cur_data=100, thresholds 127 -> step 1: spikes=0x00, all states 100, spike_valid in cycle 17. Step 2: 100+50=150>=127 -> spikes=0xFF, all states 0.
- Saturation: thresholds set to 255 via cfg, current 200, three steps -> states 200, 255 (300 saturated), spike on step 2 only when sat==255 -> spikes=0xFF after step 2, states 0.
- Per-slot config: slot 3 threshold 0, others 255, current 10 -> spikes=0x08, dbg_state[3]=0, other slots 10.
- Backpressure: cur_valid low 5 cycles on slot 2 fetch -> cur_req stays high, cur_idx=2, spike_valid delayed by exactly 5 cycles; cfg_we and step_start during stall ignored (threshold unchanged, no second step).
- Reset mid-step at slot 4 -> no spike_valid, all states 0, FSM IDLE next cycle, new step_start runs normally.
